// File: rtl/beep_sched_pkg.sv
// Shared definitions for the buzzer melody scheduler: FSM states, melody
// count, ROM field defaults and the fixed-priority pick helper.
package beep_sched_pkg;

  localparam int MEL_N       = 3;
  localparam int MEL_W       = 2;
  localparam int PER_W_DEF   = 16;
  localparam int DUR_W_DEF   = 10;
  localparam int NOTES_DEF   = 8;
  localparam int GAP_MS_DEF  = 20;
  // dur_ms of zero ends a melody early; period of zero is a silent rest
  localparam int END_DUR     = 0;
  localparam int REST_PERIOD = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FETCH = 3'd2,
    ST_PLAY  = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  function automatic logic [MEL_W-1:0] lowest_req(input logic [MEL_N-1:0] p);
    logic [MEL_W-1:0] r;
    if (p[0]) begin
      r = 2'd0;
    end else if (p[1]) begin
      r = 2'd1;
    end else if (p[2]) begin
      r = 2'd2;
    end else begin
      r = 2'd0;
    end
    return r;
  endfunction

endpackage

// File: rtl/beep_sched_if.sv
// Request/tone bundle between the key debouncer side and the PWM buzzer side.
interface beep_sched_if
  import beep_sched_pkg::*;
#(
  parameter int PER_W = PER_W_DEF
);
  logic [MEL_N-1:0] req;
  logic             stop;
  logic             tone_en;
  logic [PER_W-1:0] tone_period;
  logic [PER_W-1:0] tone_duty;
  logic             busy;
  logic [MEL_W-1:0] mel_id;
  logic             done;

  modport master (
    output req, stop,
    input  tone_en, tone_period, tone_duty, busy, mel_id, done
  );

  modport slave (
    input  req, stop,
    output tone_en, tone_period, tone_duty, busy, mel_id, done
  );
endinterface

// File: rtl/beep_note_rom.sv
// Melody note table: registered read of {period, dur_ms} at {mel, idx}.
module beep_note_rom
  import beep_sched_pkg::*;
#(
  parameter int PER_W = PER_W_DEF,
  parameter int DUR_W = DUR_W_DEF,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [MEL_W-1:0] mel,
  input  logic [IDX_W-1:0] idx,
  output logic [PER_W-1:0] period,
  output logic [DUR_W-1:0] dur_ms
);

  logic [PER_W+DUR_W-1:0] entry_s;

  function automatic logic [PER_W+DUR_W-1:0] ent(input logic [15:0] p, input logic [9:0] d);
    return {PER_W'(p), DUR_W'(d)};
  endfunction

  // Fixed melody contents; mel2 fills every slot so it ends by index wrap
  always_comb begin
    entry_s = ent(16'd0, 10'd0);
    case (mel)
      2'd0: begin
        case (idx)
          3'd0:    entry_s = ent(16'd100, 10'd3);
          3'd1:    entry_s = ent(16'd0,   10'd2);
          default: entry_s = ent(16'd0,   10'd0);
        endcase
      end
      2'd1: begin
        case (idx)
          3'd0:    entry_s = ent(16'd200, 10'd2);
          3'd1:    entry_s = ent(16'd50,  10'd1);
          default: entry_s = ent(16'd0,   10'd0);
        endcase
      end
      2'd2: begin
        case (idx)
          3'd0:    entry_s = ent(16'd40,  10'd1);
          3'd1:    entry_s = ent(16'd0,   10'd1);
          3'd2:    entry_s = ent(16'd60,  10'd2);
          3'd3:    entry_s = ent(16'd80,  10'd1);
          3'd4:    entry_s = ent(16'd0,   10'd1);
          3'd5:    entry_s = ent(16'd120, 10'd1);
          3'd6:    entry_s = ent(16'd140, 10'd2);
          3'd7:    entry_s = ent(16'd160, 10'd1);
          default: entry_s = ent(16'd0,   10'd0);
        endcase
      end
      default: entry_s = ent(16'd0, 10'd0);
    endcase
  end

  // Synchronous read port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period <= '0;
      dur_ms <= '0;
    end else begin
      period <= entry_s[PER_W+DUR_W-1:DUR_W];
      dur_ms <= entry_s[DUR_W-1:0];
    end
  end

endmodule

// File: rtl/beep_sched.sv
// Fixed-priority melody scheduler: arbitrates key pulses and steps the chosen
// melody through the note ROM, driving the PWM buzzer tone registers.
module beep_sched
  import beep_sched_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int PER_W    = PER_W_DEF,
  parameter int DUR_W    = DUR_W_DEF,
  parameter int NOTES    = NOTES_DEF,
  parameter int GAP_MS   = GAP_MS_DEF
) (
  input logic         clk,
  input logic         rst,
  beep_sched_if.slave bus
);

  localparam int MS_DIV = CLK_FREQ / 1000;
  localparam int PRE_W  = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam int IDX_W  = (NOTES > 1) ? $clog2(NOTES) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(MS_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NOTES - 1);
  localparam logic [DUR_W-1:0] GAP_LAST = DUR_W'(GAP_MS - 1);

  state_e           state_r, state_nx_s;
  logic [MEL_N-1:0] pending_r, pending_nx_s, clr_s;
  logic [MEL_W-1:0] mel_id_r, mel_nx_s;
  logic [IDX_W-1:0] idx_r, idx_nx_s, rom_idx_s;
  logic [PRE_W-1:0] pre_r;
  logic [DUR_W-1:0] ms_r, dur_r, ms_last_s;
  logic [PER_W-1:0] rom_period_s;
  logic [DUR_W-1:0] rom_dur_s;
  logic             ms_tick_s, span_end_s;
  logic             tone_en_r, busy_r, done_r;
  logic [PER_W-1:0] period_r, duty_r;

  // The ROM must see the address one cycle ahead of FETCH, so LOAD and GAP look forward
  always_comb begin
    if (state_r == ST_LOAD) begin
      rom_idx_s = '0;
    end else if (state_r == ST_GAP) begin
      rom_idx_s = idx_r + IDX_W'(1'b1);
    end else begin
      rom_idx_s = idx_r;
    end
  end

  beep_note_rom #(
    .PER_W (PER_W),
    .DUR_W (DUR_W),
    .IDX_W (IDX_W)
  ) u_rom (
    .clk    (clk),
    .rst    (rst),
    .mel    (mel_id_r),
    .idx    (rom_idx_s),
    .period (rom_period_s),
    .dur_ms (rom_dur_s)
  );

  // Millisecond tick and end-of-span detection for PLAY and GAP
  always_comb begin
    ms_tick_s = (pre_r == PRE_LAST);
    if (state_r == ST_GAP) begin
      ms_last_s = GAP_LAST;
    end else begin
      ms_last_s = dur_r - DUR_W'(1'b1);
    end
    span_end_s = ms_tick_s && (ms_r == ms_last_s);
  end

  // Next-state, pending and note index
  always_comb begin
    state_nx_s = state_r;
    mel_nx_s   = mel_id_r;
    idx_nx_s   = idx_r;
    if (state_r == ST_LOAD) begin
      clr_s = 3'b001 << mel_id_r;
    end else begin
      clr_s = 3'b000;
    end
    pending_nx_s = (pending_r & ~clr_s) | bus.req;

    case (state_r)
      ST_IDLE: begin
        if (pending_r != 3'b000) begin
          state_nx_s = ST_LOAD;
          mel_nx_s   = lowest_req(pending_r);
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        idx_nx_s   = '0;
        state_nx_s = ST_FETCH;
      end
      ST_FETCH: begin
        if (rom_dur_s == DUR_W'(END_DUR)) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (span_end_s) begin
          state_nx_s = ST_GAP;
        end else begin
          state_nx_s = ST_PLAY;
        end
      end
      ST_GAP: begin
        if (span_end_s) begin
          idx_nx_s = idx_r + IDX_W'(1'b1);
          if (idx_r == IDX_LAST) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = ST_FETCH;
          end
        end else begin
          state_nx_s = ST_GAP;
        end
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase

    // Abort outranks everything, including a request in the same cycle
    if (bus.stop) begin
      state_nx_s   = ST_IDLE;
      pending_nx_s = 3'b000;
      mel_nx_s     = mel_id_r;
    end else begin
      pending_nx_s = pending_nx_s;
    end
  end

  // FSM and arbitration state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      pending_r <= '0;
      mel_id_r  <= '0;
      idx_r     <= '0;
    end else begin
      state_r   <= state_nx_s;
      pending_r <= pending_nx_s;
      mel_id_r  <= mel_nx_s;
      idx_r     <= idx_nx_s;
    end
  end

  // Prescaler and ms counter restart whenever PLAY or GAP is entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_r <= '0;
      ms_r  <= '0;
    end else if ((state_nx_s != state_r) || ((state_r != ST_PLAY) && (state_r != ST_GAP))) begin
      pre_r <= '0;
      ms_r  <= '0;
    end else if (ms_tick_s) begin
      pre_r <= '0;
      ms_r  <= ms_r + DUR_W'(1'b1);
    end else begin
      pre_r <= pre_r + PRE_W'(1'b1);
    end
  end

  // Output registers; tone values are captured only when a note starts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tone_en_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      period_r  <= '0;
      duty_r    <= '0;
      dur_r     <= '0;
    end else begin
      busy_r <= (state_nx_s != ST_IDLE);
      done_r <= (state_nx_s == ST_DONE);
      if ((state_r == ST_FETCH) && (state_nx_s == ST_PLAY)) begin
        period_r  <= rom_period_s;
        duty_r    <= rom_period_s >> 1;
        dur_r     <= rom_dur_s;
        tone_en_r <= (rom_period_s != PER_W'(REST_PERIOD));
      end else if (state_nx_s != ST_PLAY) begin
        tone_en_r <= 1'b0;
      end else begin
        tone_en_r <= tone_en_r;
      end
    end
  end

  assign bus.tone_en     = tone_en_r;
  assign bus.tone_period = period_r;
  assign bus.tone_duty   = duty_r;
  assign bus.busy        = busy_r;
  assign bus.mel_id      = mel_id_r;
  assign bus.done        = done_r;

endmodule

// File: tb/tb_beep_sched.sv
// Scoreboard bench for beep_sched: a timeline model pushes expected tone
// segments and done pulses; a negedge monitor pops and compares them.
module tb_beep_sched;

  localparam int PER_W = 16;
  localparam int DUR_W = 10;
  localparam int NOTES = 8;
  localparam int MS    = 10;
  localparam int GAP   = 2;

  typedef struct {
    bit is_done;
    int mel;
    int period;
    int len;
    int at;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  beep_sched_if #(.PER_W(PER_W)) bus_if ();

  beep_sched #(
    .CLK_FREQ (10_000),
    .PER_W    (PER_W),
    .DUR_W    (DUR_W),
    .NOTES    (NOTES),
    .GAP_MS   (GAP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  done_cnt = 0;
  int  m_pend = 0;
  int  m_left = 0;
  int  m_load = -1;
  bit  abort_flag = 1'b0;
  ev_t exp_q[$];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Test ROM contents as stated for the melodies
  function automatic int rom_per(input int m, input int k);
    int p0[8] = '{100, 0, 0, 0, 0, 0, 0, 0};
    int p1[8] = '{200, 50, 0, 0, 0, 0, 0, 0};
    int p2[8] = '{40, 0, 60, 80, 0, 120, 140, 160};
    if (m == 0) return p0[k];
    else if (m == 1) return p1[k];
    else return p2[k];
  endfunction

  function automatic int rom_dur(input int m, input int k);
    int d0[8] = '{3, 2, 0, 0, 0, 0, 0, 0};
    int d1[8] = '{2, 1, 0, 0, 0, 0, 0, 0};
    int d2[8] = '{1, 1, 2, 1, 1, 1, 2, 1};
    if (m == 0) return d0[k];
    else if (m == 1) return d1[k];
    else return d2[k];
  endfunction

  // s = edge at which the melody is picked (IDLE->LOAD); returns cycles until IDLE
  task automatic start_mel(input int m, input int s, output int len);
    int  t;
    int  done_at;
    bit  ended;
    ev_t e;
    t = s + 1;
    ended = 1'b0;
    done_at = 0;
    for (int k = 0; k < NOTES; k++) begin
      if (!ended) begin
        if (rom_dur(m, k) == 0) begin
          done_at = t + 1;
          ended = 1'b1;
        end else begin
          if (rom_per(m, k) != 0) begin
            e.is_done = 1'b0; e.mel = m; e.period = rom_per(m, k);
            e.len = rom_dur(m, k) * MS; e.at = t + 1;
            exp_q.push_back(e);
          end
          t = t + 1 + rom_dur(m, k) * MS + GAP * MS;
        end
      end
    end
    if (!ended) done_at = t;
    e.is_done = 1'b1; e.mel = m; e.period = 0; e.len = 0; e.at = done_at;
    exp_q.push_back(e);
    len = done_at + 1 - s;
  endtask

  // Reference model: pending set, a busy-until counter and arbitration
  initial begin : model
    int pold;
    int len;
    int m;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst || bus_if.stop) begin
        m_pend = 0; m_left = 0; m_load = -1;
        exp_q.delete();
        abort_flag = 1'b1;
      end else begin
        pold = m_pend;
        if (m_load >= 0) begin
          m_pend = m_pend & ~(1 << m_load);
          m_load = -1;
        end
        m_pend = m_pend | int'(bus_if.req);
        if (m_left > 0) m_left--;
        if (m_left == 0 && pold != 0) begin
          m = (pold & 1) ? 0 : ((pold & 2) ? 1 : 2);
          start_mel(m, cyc, len);
          m_left = len + 1;
          m_load = m;
        end
      end
    end
  end

  task automatic pop_check(input bit is_done, input int mel, input int per, input int duty,
                           input int len, input int at);
    ev_t e;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL unexpected_%s: mel=%0d at cycle %0d, nothing expected",
               is_done ? "done" : "tone", mel, at);
    end else begin
      e = exp_q.pop_front();
      chk("ev_kind", is_done, e.is_done);
      chk("ev_mel", mel, e.mel);
      chk("ev_cycle", at, e.at);
      if (!is_done) begin
        chk("tone_period", per, e.period);
        chk("tone_duty", duty, e.period >> 1);
        chk("tone_len", len, e.len);
      end
    end
  endtask

  // Monitor: tone_en high runs and done pulses become observed events
  initial begin : monitor
    bit in_tone;
    int t_start, t_per, t_duty, t_mel;
    in_tone = 1'b0;
    t_start = 0; t_per = 0; t_duty = 0; t_mel = 0;
    forever begin
      @(negedge clk);
      if (abort_flag) begin
        abort_flag = 1'b0;
        in_tone = 1'b0;
      end else begin
        if (bus_if.tone_en && !in_tone) begin
          in_tone = 1'b1;
          t_start = cyc;
          t_per = int'(bus_if.tone_period);
          t_duty = int'(bus_if.tone_duty);
          t_mel = int'(bus_if.mel_id);
        end else if (!bus_if.tone_en && in_tone) begin
          in_tone = 1'b0;
          pop_check(1'b0, t_mel, t_per, t_duty, cyc - t_start, t_start);
        end
        if (bus_if.done) begin
          done_cnt++;
          pop_check(1'b1, int'(bus_if.mel_id), 0, 0, 0, cyc);
        end
      end
    end
  end

  task automatic pulse(input logic [2:0] bits, input logic stp);
    @(posedge clk);
    #1 bus_if.req = bits; bus_if.stop = stp;
    @(posedge clk);
    #1 bus_if.req = 3'b000; bus_if.stop = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!(m_left == 0 && m_pend == 0 && m_load < 0 && !bus_if.busy) && n < max);
    if (n >= max) begin
      total++; bad++;
      $display("FAIL idle_timeout: still busy after %0d cycles", max);
    end
  endtask

  task automatic wait_tone(input int max);
    int n;
    n = 0;
    while (!bus_if.tone_en && n < max) begin
      @(posedge clk);
      #1 n++;
    end
    if (!bus_if.tone_en) begin
      total++; bad++;
      $display("FAIL tone_timeout: tone_en low after %0d cycles", max);
    end
  endtask

  initial begin : stim
    int d0;
    bus_if.req = 3'b000;
    bus_if.stop = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_tone_en", bus_if.tone_en, 0);
    chk("rst_period", bus_if.tone_period, 0);
    chk("rst_duty", bus_if.tone_duty, 0);
    chk("rst_busy", bus_if.busy, 0);
    chk("rst_mel_id", bus_if.mel_id, 0);
    chk("rst_done", bus_if.done, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 chk("post_rst_busy", bus_if.busy, 0);

    // single melody with latency checks
    d0 = done_cnt;
    pulse(3'b001, 1'b0);
    #0 chk("lat_busy_n", bus_if.busy, 0);
    @(posedge clk);
    #1 chk("lat_busy_n1", bus_if.busy, 1);
    @(posedge clk);
    #1 chk("lat_tone_n2", bus_if.tone_en, 0);
    @(posedge clk);
    #1 chk("lat_tone_n3", bus_if.tone_en, 1);
    chk("lat_period", bus_if.tone_period, 100);
    chk("lat_duty", bus_if.tone_duty, 50);
    wait_idle(2000);
    chk("single_done", done_cnt - d0, 1);

    // simultaneous requests: mel1 then mel2 (mel2 ends by index wrap)
    d0 = done_cnt;
    pulse(3'b110, 1'b0);
    wait_idle(3000);
    chk("prio_done", done_cnt - d0, 2);
    chk("prio_last_mel", bus_if.mel_id, 2);

    // replay of the melody currently playing
    d0 = done_cnt;
    pulse(3'b001, 1'b0);
    wait_tone(100);
    pulse(3'b001, 1'b0);
    wait_idle(3000);
    chk("replay_done", done_cnt - d0, 2);

    // stop during PLAY with mel2 pending
    d0 = done_cnt;
    pulse(3'b001, 1'b0);
    wait_tone(100);
    pulse(3'b100, 1'b0);
    repeat (3) @(posedge clk);
    pulse(3'b000, 1'b1);
    chk("stop_tone_en", bus_if.tone_en, 0);
    chk("stop_busy", bus_if.busy, 0);
    repeat (400) @(posedge clk);
    #1 chk("stop_stays_idle", bus_if.busy, 0);
    chk("stop_no_done", done_cnt - d0, 0);

    // asynchronous reset in the middle of a melody
    pulse(3'b010, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_tone_en", bus_if.tone_en, 0);
    chk("midrst_busy", bus_if.busy, 0);
    chk("midrst_period", bus_if.tone_period, 0);
    chk("midrst_mel_id", bus_if.mel_id, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("midrst_busy_after", bus_if.busy, 0);

    // randomized requests with occasional stops
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(1, 150)) @(posedge clk);
      if ($urandom_range(0, 9) == 0) begin
        pulse(3'($urandom_range(0, 7)), 1'b1);
      end else begin
        pulse(3'($urandom_range(1, 7)), 1'b0);
      end
    end
    wait_idle(20000);
    repeat (2) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
